div_ratio_ctrl: RTL and testbench
=================================

DIV_RATIO_CTRL -- requirements
Module: div_ratio_ctrl

Interface
REQ-001: Parameter DEFAULT_RATIO, default 3, SHALL set the divide ratio loaded at reset (legal range 1..15).
REQ-002: clk  input  1  sole clock; all state SHALL update on its rising edge only.
REQ-003: rst  input  1  synchronous, active-high reset, sampled on the rising edge of clk.
REQ-004: en  input  1  run enable; level-sensitive.
REQ-005: req  input  1  ratio-change request; sampled every cycle.
REQ-006: ratio  input  4  requested divide ratio N; valid when req=1.
REQ-007: ack  output  1  one-cycle pulse; a request completed (applied or rejected).
REQ-008: err  output  1  one-cycle pulse, coincident with ack; request rejected.
REQ-009: busy  output  1  high while an accepted request is pending.
REQ-010: ce  output  1  one-cycle clock-enable pulse at the start of each divided period.
REQ-011: t  output  1  divided-clock output.
REQ-012: cur_ratio  output  4  divide ratio currently in effect.

Function
REQ-013: States SHALL be IDLE and RUN, plus a pending flag (pend) holding pend_ratio[3:0]; busy SHALL equal pend.
REQ-014: Period counter cnt[3:0] SHALL be held at 0 in IDLE; in RUN it SHALL count 0..cur_ratio-1 and wrap to 0 on the edge where cnt==cur_ratio-1 (the "boundary edge").
REQ-015: ce SHALL be 1 when state==RUN and cnt==0, otherwise 0.
REQ-016: t SHALL be 1 when state==RUN and cnt < (cur_ratio+1)>>1, otherwise 0: N=1 gives constant 1, N=2 gives 1,0, N=3 gives 1,1,0, N=5 gives 1,1,1,0,0.
REQ-017: ce and t SHALL be decoded from registered state only, with no combinational path from any input.
REQ-018: IDLE->RUN SHALL occur on the edge where en=1; the first RUN cycle SHALL have cnt=0, so ce=1.
REQ-019: In RUN with en=0, the current period SHALL complete; RUN->IDLE SHALL occur on the next boundary edge, with no truncated period.
REQ-020: If en returns to 1 before that boundary edge, the block SHALL stay in RUN with no gap.
REQ-021: A request (req=1) SHALL be accepted only when pend=0; req while pend=1 SHALL be ignored, with no queueing and no ack.
REQ-022: An accepted request with ratio==0 SHALL be rejected: ack=1 and err=1 in the next cycle; cur_ratio and pend unchanged.
REQ-023: An accepted legal request SHALL load cur_ratio on the same edge if state==IDLE or the edge is a boundary edge; otherwise it SHALL set pend=1 and pend_ratio=ratio.
REQ-024: With pend=1, the next boundary edge SHALL load cur_ratio=pend_ratio and clear pend; cnt wraps to 0 on that same edge.
REQ-025: ack (err=0) SHALL be high in exactly the one cycle following the load edge, coincident with the new cur_ratio value.
REQ-026: A ratio change SHALL never occur mid-period; every period SHALL run exactly its ratio's length.
REQ-027: If en=0 and pend=1 at a boundary edge, the pending load SHALL still be applied and acked, and the state SHALL go to IDLE.
REQ-028: req and en=1 in the same IDLE cycle: cur_ratio SHALL load and the state SHALL enter RUN on the same edge; the first period SHALL use the new ratio.
REQ-029: Loading the ratio already in effect SHALL behave as a normal load, including the ack.

Reset
REQ-030: While rst=1 on an edge: state=IDLE, cnt=0, cur_ratio=DEFAULT_RATIO, pend=0, pend_ratio=0, ack=0, err=0; hence busy=0, ce=0, t=0.
REQ-031: rst SHALL take priority over en and req; a pending request SHALL be discarded without ack.

Verification
REQ-032: Reset, then en=1 held -> ce pulses every 3 cycles starting the first RUN cycle; t repeats 1,1,0; cur_ratio=3.
REQ-033: N=3 running, req=1 with ratio=5 during the cycle cnt=0 -> busy=1 for 2 cycles, load at boundary, ack=1 for 1 cycle with cur_ratio=5; t then repeats 1,1,1,0,0.
REQ-034: req with ratio=0 -> ack=1 and err=1 for one cycle; cur_ratio unchanged; busy stays 0. A second req while busy=1 -> no ack, cur_ratio unaffected by it.
REQ-035: N=5 running, en dropped at cnt=1 -> 3 more RUN cycles complete the period, then IDLE with t=0 and ce=0; en=1 again -> ce=1 on the first RUN cycle.
REQ-036: rst asserted while busy=1 -> next cycle busy=0, ack=0, cur_ratio=DEFAULT_RATIO, t=0.
REQ-037: Ratio 1 then ratio 2 in IDLE with en=1 -> N=1: t constant 1, ce every cycle; N=2: t alternates 1,0, ce every other cycle.

Source files
------------

// File: rtl/div_ratio_ctrl_if.sv
// Request/status bundle for the divide-ratio controller.
// The master drives enable and ratio requests; the slave returns handshake and divider status.
interface div_ratio_ctrl_if;
  logic       en;
  logic       req;
  logic [3:0] ratio;
  logic       ack;
  logic       err;
  logic       busy;
  logic       ce;
  logic       t;
  logic [3:0] cur_ratio;

  modport master (
    output en, req, ratio,
    input  ack, err, busy, ce, t, cur_ratio
  );

  modport slave (
    input  en, req, ratio,
    output ack, err, busy, ce, t, cur_ratio
  );
endinterface

// File: rtl/div_ratio_ctrl.sv
// Programmable clock-enable divider whose ratio changes are deferred to period boundaries.
// Requests are acked once the new ratio is in effect; a zero ratio is rejected.
//
// state | meaning
// ------+------------------------------------------------------------
// IDLE  | divider stopped, cnt held at 0, ce and t low
// RUN   | cnt sweeps 0..cur_ratio-1, ce at cnt 0, t high for the first half
module div_ratio_ctrl #(
  parameter logic [3:0] DEFAULT_RATIO = 4'd3
) (
  input logic              clk,
  input logic              rst,
  div_ratio_ctrl_if.slave  bus
);

  typedef enum logic {IDLE, RUN} state_t;

  state_t     state_q, state_d;
  logic [3:0] cnt_q, cnt_d;
  logic [3:0] cur_ratio_q, cur_ratio_d;
  logic [3:0] pend_ratio_q, pend_ratio_d;
  logic       pend_q, pend_d;
  logic       ack_q, ack_d;
  logic       err_q, err_d;
  logic       boundary;
  logic       accept;
  logic [4:0] t_limit;

  always_comb begin
    boundary     = (state_q == RUN) && (cnt_q == (cur_ratio_q - 4'd1));
    accept       = bus.req && !pend_q;
    state_d      = state_q;
    cnt_d        = cnt_q;
    cur_ratio_d  = cur_ratio_q;
    pend_d       = pend_q;
    pend_ratio_d = pend_ratio_q;
    ack_d        = 1'b0;
    err_d        = 1'b0;

    case (state_q)
      IDLE: begin
        cnt_d = 4'd0;
        if (bus.en) state_d = RUN;
      end
      RUN: begin
        if (boundary) begin
          cnt_d = 4'd0;
          if (!bus.en) state_d = IDLE;
        end else begin
          cnt_d = cnt_q + 4'd1;
        end
      end
      default: begin
        state_d = IDLE;
        cnt_d   = 4'd0;
      end
    endcase

    // A pending ratio only ever lands on a boundary so no period is truncated.
    if (pend_q && boundary) begin
      cur_ratio_d = pend_ratio_q;
      pend_d      = 1'b0;
      ack_d       = 1'b1;
    end

    if (accept) begin
      if (bus.ratio == 4'd0) begin
        ack_d = 1'b1;
        err_d = 1'b1;
      end else if ((state_q == IDLE) || boundary) begin
        cur_ratio_d = bus.ratio;
        ack_d       = 1'b1;
      end else begin
        pend_d       = 1'b1;
        pend_ratio_d = bus.ratio;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q      <= IDLE;
      cnt_q        <= 4'd0;
      cur_ratio_q  <= DEFAULT_RATIO;
      pend_q       <= 1'b0;
      pend_ratio_q <= 4'd0;
      ack_q        <= 1'b0;
      err_q        <= 1'b0;
    end else begin
      state_q      <= state_d;
      cnt_q        <= cnt_d;
      cur_ratio_q  <= cur_ratio_d;
      pend_q       <= pend_d;
      pend_ratio_q <= pend_ratio_d;
      ack_q        <= ack_d;
      err_q        <= err_d;
    end
  end

  // High phase is ceil(N/2) counts, so odd ratios lean high.
  assign t_limit = ({1'b0, cur_ratio_q} + 5'd1) >> 1;

  assign bus.ce        = (state_q == RUN) && (cnt_q == 4'd0);
  assign bus.t         = (state_q == RUN) && ({1'b0, cnt_q} < t_limit);
  assign bus.ack       = ack_q;
  assign bus.err       = err_q;
  assign bus.busy      = pend_q;
  assign bus.cur_ratio = cur_ratio_q;

endmodule

// File: tb/tb_div_ratio_ctrl.sv
// Directed cycle-by-cycle bench for div_ratio_ctrl: a vector table plus a few hand sequences.
module tb_div_ratio_ctrl;

  typedef struct {
    logic       rst;
    logic       en;
    logic       req;
    logic [3:0] ratio;
    logic       ack;
    logic       err;
    logic       busy;
    logic       ce;
    logic       t;
    logic [3:0] cur;
  } vec_t;

  logic clk;
  logic rst;
  int   errors = 0;
  int   checks = 0;
  vec_t vecs[$];

  div_ratio_ctrl_if bus ();

  div_ratio_ctrl #(.DEFAULT_RATIO(4'd3)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  function automatic void add(input logic r, input logic e, input logic q, input logic [3:0] ra,
                              input logic a, input logic er, input logic b, input logic c,
                              input logic tt, input logic [3:0] cu);
    vec_t v;
    v.rst = r; v.en = e; v.req = q; v.ratio = ra;
    v.ack = a; v.err = er; v.busy = b; v.ce = c; v.t = tt; v.cur = cu;
    vecs.push_back(v);
  endfunction

  task automatic step(input logic r, input logic e, input logic q, input logic [3:0] ra);
    rst       = r;
    bus.en    = e;
    bus.req   = q;
    bus.ratio = ra;
    @(posedge clk);
    #1;
  endtask

  task automatic check(input string name, input logic a, input logic er, input logic b,
                       input logic c, input logic tt, input logic [3:0] cu);
    logic [8:0] act;
    logic [8:0] exp;
    act = {bus.ack, bus.err, bus.busy, bus.ce, bus.t, bus.cur_ratio};
    exp = {a, er, b, c, tt, cu};
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got ack=%b err=%b busy=%b ce=%b t=%b cur=%0d, want ack=%b err=%b busy=%b ce=%b t=%b cur=%0d",
               name, bus.ack, bus.err, bus.busy, bus.ce, bus.t, bus.cur_ratio, a, er, b, c, tt, cu);
    end
  endtask

  initial begin
    rst = 1'b1; bus.en = 1'b0; bus.req = 1'b0; bus.ratio = 4'd0;

    //   rst en req ratio | ack err busy ce t cur
    add(1, 0, 0, 0,  0, 0, 0, 0, 0, 3);
    add(1, 1, 1, 7,  0, 0, 0, 0, 0, 3);
    add(0, 1, 0, 0,  0, 0, 0, 1, 1, 3);
    add(0, 1, 0, 0,  0, 0, 0, 0, 1, 3);
    add(0, 1, 0, 0,  0, 0, 0, 0, 0, 3);
    add(0, 1, 0, 0,  0, 0, 0, 1, 1, 3);
    add(0, 1, 1, 5,  0, 0, 1, 0, 1, 3);
    add(0, 1, 0, 0,  0, 0, 1, 0, 0, 3);
    add(0, 1, 0, 0,  1, 0, 0, 1, 1, 5);
    add(0, 1, 0, 0,  0, 0, 0, 0, 1, 5);
    add(0, 1, 0, 0,  0, 0, 0, 0, 1, 5);
    add(0, 1, 0, 0,  0, 0, 0, 0, 0, 5);
    add(0, 1, 0, 0,  0, 0, 0, 0, 0, 5);
    add(0, 1, 0, 0,  0, 0, 0, 1, 1, 5);
    add(0, 1, 1, 0,  1, 1, 0, 0, 1, 5);
    add(0, 1, 1, 9,  0, 0, 1, 0, 1, 5);
    add(0, 1, 1, 2,  0, 0, 1, 0, 0, 5);
    add(0, 1, 0, 0,  0, 0, 1, 0, 0, 5);
    add(0, 1, 0, 0,  1, 0, 0, 1, 1, 9);
    add(0, 0, 1, 1,  0, 0, 1, 0, 1, 9);
    add(0, 0, 0, 0,  0, 0, 1, 0, 1, 9);
    add(0, 0, 0, 0,  0, 0, 1, 0, 1, 9);
    add(0, 0, 0, 0,  0, 0, 1, 0, 1, 9);
    add(0, 0, 0, 0,  0, 0, 1, 0, 0, 9);
    add(0, 0, 0, 0,  0, 0, 1, 0, 0, 9);
    add(0, 0, 0, 0,  0, 0, 1, 0, 0, 9);
    add(0, 0, 0, 0,  0, 0, 1, 0, 0, 9);
    add(0, 0, 0, 0,  1, 0, 0, 0, 0, 1);
    add(0, 0, 0, 0,  0, 0, 0, 0, 0, 1);
    add(0, 1, 0, 0,  0, 0, 0, 1, 1, 1);
    add(0, 1, 0, 0,  0, 0, 0, 1, 1, 1);
    add(0, 1, 0, 0,  0, 0, 0, 1, 1, 1);
    add(0, 0, 0, 0,  0, 0, 0, 0, 0, 1);
    add(0, 1, 1, 2,  1, 0, 0, 1, 1, 2);
    add(0, 1, 0, 0,  0, 0, 0, 0, 0, 2);
    add(0, 1, 0, 0,  0, 0, 0, 1, 1, 2);
    add(0, 1, 0, 0,  0, 0, 0, 0, 0, 2);
    add(0, 1, 1, 2,  1, 0, 0, 1, 1, 2);
    add(0, 1, 0, 0,  0, 0, 0, 0, 0, 2);

    foreach (vecs[i]) begin
      step(vecs[i].rst, vecs[i].en, vecs[i].req, vecs[i].ratio);
      check($sformatf("vec%0d", i), vecs[i].ack, vecs[i].err, vecs[i].busy,
            vecs[i].ce, vecs[i].t, vecs[i].cur);
    end

    // Boundary load to N=5, then drop en at cnt=1: period finishes, then IDLE, then restart.
    step(0, 1, 1, 5); check("load5_at_boundary", 1, 0, 0, 1, 1, 5);
    step(0, 1, 0, 0); check("n5_cnt1",           0, 0, 0, 0, 1, 5);
    step(0, 0, 0, 0); check("drop_cnt2",         0, 0, 0, 0, 1, 5);
    step(0, 0, 0, 0); check("drop_cnt3",         0, 0, 0, 0, 0, 5);
    step(0, 0, 0, 0); check("drop_cnt4",         0, 0, 0, 0, 0, 5);
    step(0, 0, 0, 0); check("drop_idle",         0, 0, 0, 0, 0, 5);
    step(0, 0, 0, 0); check("drop_idle_hold",    0, 0, 0, 0, 0, 5);
    step(0, 1, 0, 0); check("restart_ce",        0, 0, 0, 1, 1, 5);

    // en low for two cycles but back before the boundary: no gap.
    step(0, 0, 0, 0); check("blip_cnt1",         0, 0, 0, 0, 1, 5);
    step(0, 0, 0, 0); check("blip_cnt2",         0, 0, 0, 0, 1, 5);
    step(0, 1, 0, 0); check("blip_cnt3",         0, 0, 0, 0, 0, 5);
    step(0, 1, 0, 0); check("blip_cnt4",         0, 0, 0, 0, 0, 5);
    step(0, 1, 0, 0); check("blip_wrap_ce",      0, 0, 0, 1, 1, 5);

    // Reset while a request is pending discards it.
    step(0, 1, 1, 7); check("pend7",             0, 0, 1, 0, 1, 5);
    step(1, 1, 0, 0); check("rst_while_busy",    0, 0, 0, 0, 0, 3);
    step(0, 1, 0, 0); check("post_rst_cnt0",     0, 0, 0, 1, 1, 3);
    step(0, 1, 0, 0); check("post_rst_cnt1",     0, 0, 0, 0, 1, 3);
    step(0, 1, 0, 0); check("post_rst_cnt2",     0, 0, 0, 0, 0, 3);
    step(0, 1, 0, 0); check("post_rst_no_ack",   0, 0, 0, 1, 1, 3);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
